// File: rtl/gcd_operand_sequencer.sv
// Host-side initiator for the serial-load GCD unit: loads A then B onto the shared
// data bus, waits for done (or a timeout), and returns the result on a valid/ready port.
module gcd_operand_sequencer #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 1023,
  parameter int CNT_W   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_timeout,
  output logic             gcd_start,
  output logic [WIDTH-1:0] gcd_data,
  input  logic             gcd_done,
  input  logic [WIDTH-1:0] gcd_result
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEND_A = 3'd1,
    ST_SEND_B = 3'd2,
    ST_WAIT   = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_gcd_q, out_gcd_d;
  logic               out_timeout_q, out_timeout_d;
  logic               gcd_start_q, gcd_start_d;
  logic [WIDTH-1:0]   gcd_data_q, gcd_data_d;

  // Next-state and registered-output computation.
  always_comb begin
    state_d       = state_q;
    b_d           = b_q;
    cnt_d         = cnt_q;
    out_gcd_d     = out_gcd_q;
    out_timeout_d = out_timeout_q;
    gcd_data_d    = gcd_data_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          b_d = in_b;
          // A zero operand would never terminate the subtractive core; answer locally.
          if ((in_a != '0) && (in_b != '0)) begin
            state_d    = ST_SEND_A;
            gcd_data_d = in_a;
          end else begin
            state_d       = ST_HOLD;
            out_gcd_d     = in_a | in_b;
            out_timeout_d = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND_A: begin
        state_d    = ST_SEND_B;
        gcd_data_d = b_q;
      end
      ST_SEND_B: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (gcd_done) begin
          state_d       = ST_HOLD;
          out_gcd_d     = gcd_result;
          out_timeout_d = 1'b0;
        end else if (cnt_q == TIMEOUT_C) begin
          state_d       = ST_HOLD;
          out_gcd_d     = '0;
          out_timeout_d = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_HOLD: begin
        if (out_valid_q && out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Handshake and strobe outputs are decoded from the next state so they stay registered.
    gcd_start_d = (state_d == ST_SEND_A);
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_HOLD);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      b_q           <= '0;
      cnt_q         <= '0;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_gcd_q     <= '0;
      out_timeout_q <= 1'b0;
      gcd_start_q   <= 1'b0;
      gcd_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      b_q           <= b_d;
      cnt_q         <= cnt_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_gcd_q     <= out_gcd_d;
      out_timeout_q <= out_timeout_d;
      gcd_start_q   <= gcd_start_d;
      gcd_data_q    <= gcd_data_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_gcd     = out_gcd_q;
  assign out_timeout = out_timeout_q;
  assign gcd_start   = gcd_start_q;
  assign gcd_data    = gcd_data_q;

endmodule

// File: tb/tb_gcd_operand_sequencer.sv
// Scoreboard bench for gcd_operand_sequencer: a behavioural GCD core model on the main
// instance, and a second instance with a short timeout driven by hand.
module tb_gcd_operand_sequencer;
  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, out_timeout;
  logic [W-1:0] in_a, in_b, out_gcd, gcd_data, gcd_result;
  logic         gcd_start, gcd_done;

  logic         t_in_valid, t_in_ready, t_out_valid, t_out_ready, t_out_timeout;
  logic [W-1:0] t_in_a, t_in_b, t_out_gcd, t_gcd_data, t_gcd_result;
  logic         t_gcd_start, t_gcd_done;

  gcd_operand_sequencer #(.WIDTH(W), .TIMEOUT(1023), .CNT_W(10)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_gcd(out_gcd), .out_timeout(out_timeout),
    .gcd_start(gcd_start), .gcd_data(gcd_data), .gcd_done(gcd_done), .gcd_result(gcd_result)
  );

  gcd_operand_sequencer #(.WIDTH(W), .TIMEOUT(15), .CNT_W(4)) u_dut_to (
    .clk(clk), .rst_n(rst_n),
    .in_valid(t_in_valid), .in_ready(t_in_ready), .in_a(t_in_a), .in_b(t_in_b),
    .out_valid(t_out_valid), .out_ready(t_out_ready), .out_gcd(t_out_gcd), .out_timeout(t_out_timeout),
    .gcd_start(t_gcd_start), .gcd_data(t_gcd_data), .gcd_done(t_gcd_done), .gcd_result(t_gcd_result)
  );

  int           errors = 0;
  int           checks = 0;
  int           pushes = 0;
  int           pops   = 0;
  int           start_cnt = 0;
  int           mdelay = 3;
  bit           mute = 1'b0;
  logic [W:0]   sb[$];
  logic [W-1:0] ma, mb;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Output monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    logic [W:0] exp;
    if (gcd_start) start_cnt++;
    if (rst_n && out_valid && out_ready) begin
      pops++;
      if (sb.size() == 0) begin
        check_val("sb_underflow", sb.size(), 1);
      end else begin
        exp = sb.pop_front();
        check_val("out_gcd", out_gcd, exp[W-1:0]);
        check_val("out_timeout", out_timeout, exp[W]);
      end
    end
  end

  // GCD core model: latches A and B, then raises done for one cycle after mdelay WAIT cycles.
  always begin
    @(negedge clk);
    if (gcd_start) begin
      ma = gcd_data;
      @(negedge clk);
      mb = gcd_data;
      if (!mute) begin
        repeat (mdelay) @(posedge clk);
        #1;
        gcd_done   = 1'b1;
        gcd_result = ref_gcd(ma, mb);
        @(posedge clk);
        #1;
        gcd_done   = 1'b0;
        gcd_result = '0;
      end
    end
  end

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    int n;
    n = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_val("accept_bound", in_ready, 1);
    if (push) begin
      sb.push_back({1'b0, ((a == 0) || (b == 0)) ? (a | b) : ref_gcd(a, b)});
      pushes++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int s0;
    logic [W-1:0] ra, rb;
    logic [W-1:0] zt_a[3] = '{16'd0, 16'd0, 16'd48};
    logic [W-1:0] zt_b[3] = '{16'd35, 16'd0, 16'd0};

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    gcd_done = 1'b0; gcd_result = '0;
    t_in_valid = 1'b0; t_in_a = '0; t_in_b = '0; t_out_ready = 1'b1;
    t_gcd_done = 1'b0; t_gcd_result = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_in_ready", in_ready, 0);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_gcd_start", gcd_start, 0);
    check_val("rst_gcd_data", gcd_data, 0);
    check_val("rst_out_gcd", out_gcd, 0);
    check_val("rst_out_timeout", out_timeout, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    check_val("rel_in_ready_0", in_ready, 0);
    @(negedge clk);
    check_val("rel_in_ready_1", in_ready, 1);
    @(posedge clk); #1;

    // Nominal (143,78), done after 20 WAIT cycles
    mdelay = 20;
    s0 = start_cnt;
    send(16'd143, 16'd78, 1'b1);
    @(negedge clk);
    check_val("nom_start_hi", gcd_start, 1);
    check_val("nom_data_a", gcd_data, 143);
    @(negedge clk);
    check_val("nom_start_lo", gcd_start, 0);
    check_val("nom_data_b", gcd_data, 78);
    n = 0;
    while (!gcd_done && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val("nom_done_seen", gcd_done, 1);
    check_val("nom_valid_at_done", out_valid, 0);
    @(negedge clk);
    check_val("nom_valid_after_done", out_valid, 1);
    check_val("nom_gcd", out_gcd, 13);
    check_val("nom_timeout", out_timeout, 0);
    check_val("nom_start_cycles", start_cnt - s0, 1);
    @(posedge clk); #1;
    drain("nom_drain");

    // Zero bypass
    mdelay = 3;
    s0 = start_cnt;
    for (int i = 0; i < 3; i++) begin
      send(zt_a[i], zt_b[i], 1'b1);
      @(negedge clk);
      check_val("zb_valid_next", out_valid, 1);
      @(posedge clk); #1;
    end
    check_val("zb_no_start", start_cnt - s0, 0);
    drain("zb_drain");

    // Backpressure on (36,60), second pair waiting at the input
    out_ready = 1'b0;
    send(16'd36, 16'd60, 1'b1);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_val("bp_valid_seen", out_valid, 1);
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = 16'd5; in_b = 16'd10;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_val("bp_valid_hold", out_valid, 1);
      check_val("bp_gcd_hold", out_gcd, 12);
      check_val("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1; out_ready = 1'b1;
    @(negedge clk);
    check_val("bp_in_ready_hs", in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("bp_in_ready_after", in_ready, 1);
    sb.push_back({1'b0, 16'd5});
    pushes++;
    @(posedge clk); #1; in_valid = 1'b0;
    drain("bp_drain");

    // Reset during WAIT (core hung)
    mute = 1'b1;
    send(16'd100, 16'd30, 1'b0);
    repeat (5) @(negedge clk);
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("rw_out_valid", out_valid, 0);
    check_val("rw_gcd_start", gcd_start, 0);
    check_val("rw_in_ready", in_ready, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_val("rw_in_ready_after", in_ready, 1);
    @(posedge clk); #1;

    // Reset during HOLD
    out_ready = 1'b0;
    send(16'd0, 16'd9, 1'b0);
    @(negedge clk);
    check_val("rh_in_hold", out_valid, 1);
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("rh_out_valid", out_valid, 0);
    check_val("rh_gcd_start", gcd_start, 0);
    @(posedge clk); #1; rst_n = 1'b1; out_ready = 1'b1; mute = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("rh_in_ready_after", in_ready, 1);
    @(posedge clk); #1;
    send(16'd17, 16'd51, 1'b1);
    drain("rh_drain");

    // Back-to-back random nonzero pairs
    mdelay = 2;
    for (int i = 0; i < 8; i++) begin
      ra = W'($urandom_range(1, 5000));
      rb = W'($urandom_range(1, 5000));
      send(ra, rb, 1'b1);
    end
    drain("b2b_drain");
    check_val("b2b_pop_count", pops, pushes);

    // Timeout instance: hung core
    t_in_a = 16'd10; t_in_b = 16'd4; t_in_valid = 1'b1;
    @(negedge clk);
    check_val("to_in_ready", t_in_ready, 1);
    @(posedge clk); #1; t_in_valid = 1'b0;
    @(negedge clk);
    check_val("to_start", t_gcd_start, 1);
    @(negedge clk);
    n = 0;
    while (!t_out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_val("to_latency", n, 17);
    check_val("to_gcd", t_out_gcd, 0);
    check_val("to_flag", t_out_timeout, 1);
    @(posedge clk); #1;

    // Timeout instance: done coincides with the limit
    t_in_a = 16'd21; t_in_b = 16'd14; t_in_valid = 1'b1;
    @(negedge clk);
    check_val("tl_in_ready", t_in_ready, 1);
    @(posedge clk); #1; t_in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    repeat (15) @(negedge clk);
    @(posedge clk); #1; t_gcd_done = 1'b1; t_gcd_result = 16'd7;
    @(negedge clk);
    check_val("tl_valid_at_limit", t_out_valid, 0);
    @(posedge clk); #1; t_gcd_done = 1'b0; t_gcd_result = '0;
    @(negedge clk);
    check_val("tl_valid", t_out_valid, 1);
    check_val("tl_gcd", t_out_gcd, 7);
    check_val("tl_flag", t_out_timeout, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gcd_operand_sequencer.md
Name: gcd_operand_sequencer

Overview:
Host-side initiator for the team's serial-load GCD unit (datapath + controller pair with start/data_in/done). Accepts an operand pair on a valid/ready input port and sequences it onto the unit's shared data_in bus: A first, then B on the next cycle. It then waits for done, captures the result, and returns it on a valid/ready output port. It also handles the zero-operand cases and a hung unit (timeout) locally, so the subtractive GCD core is never started on inputs it cannot terminate on.

Parameters:
WIDTH, 16, operand/result width; matches the GCD datapath bus.
TIMEOUT, 1023, maximum cycles spent in WAIT before aborting; must be >= 1.
CNT_W, 10, timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  synchronous active-low reset, sampled on rising clk.
in_valid  input  1  operand pair valid.
in_ready  output  1  sequencer can accept a pair.
in_a  input  WIDTH  operand A.
in_b  input  WIDTH  operand B.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts result.
out_gcd  output  WIDTH  GCD result.
out_timeout  output  1  qualifies out_gcd; 1 = core timed out, out_gcd = 0.
gcd_start  output  1  start pulse to GCD controller.
gcd_data  output  WIDTH  drives GCD data_in.
gcd_done  input  1  GCD controller done.
gcd_result  input  WIDTH  GCD datapath A register output.

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE. in_ready=0 during reset, 1 the cycle after. out_valid=0, out_gcd=0, out_timeout=0, gcd_start=0, gcd_data=0, timeout counter=0. Reset overrides everything, including mid-transaction and a pending output; the in-flight pair is dropped.
- States: IDLE, SEND_A, SEND_B, WAIT, HOLD.
- IDLE: in_ready=1. A transfer occurs when in_valid & in_ready at the clk edge; in_a and in_b are registered.
  - Both operands nonzero -> SEND_A.
  - Either operand zero -> HOLD directly, with out_gcd = in_a | in_b (gcd(x,0)=x, gcd(0,0)=0) and out_timeout=0. The core is not touched.
- SEND_A (1 cycle): gcd_start=1, gcd_data=A. -> SEND_B.
- SEND_B (1 cycle): gcd_start=0, gcd_data=B. Timeout counter cleared. -> WAIT.
- WAIT: gcd_data holds B, gcd_start=0. Counter increments each cycle.
  - gcd_done=1: register gcd_result into out_gcd, out_timeout=0, -> HOLD.
  - Else if counter == TIMEOUT: out_gcd=0, out_timeout=1, -> HOLD.
  - If done and the timeout limit coincide on the same cycle, done wins.
- HOLD: out_valid=1; out_gcd and out_timeout stable while out_valid & !out_ready. On out_valid & out_ready: -> IDLE, out_valid=0 next cycle.
- in_ready=0 in every state except IDLE, so there is no pipelining: exactly one transaction is in flight.
- Minimum latency for a nonzero pair: input accept edge -> gcd_start high next cycle -> B one cycle later -> WAIT. out_valid rises 1 cycle after the gcd_done sample. Zero bypass: out_valid the cycle after accept.
- gcd_done is ignored outside WAIT; a stray done in IDLE, SEND_A or SEND_B has no effect.
- All outputs are registered. No combinational path from any input to any output.
- gcd_data retains its last value in IDLE and HOLD; it is don't-care to the core.

Test Plan:
- Nominal: in_a=143, in_b=78, with a GCD model asserting done after 20 cycles and result=13 -> gcd_start high exactly 1 cycle with gcd_data=143, next cycle gcd_data=78, then out_gcd=13, out_timeout=0, out_valid 1 cycle after done.
- Zero bypass: (0,35) -> out_gcd=35; (0,0) -> out_gcd=0; (48,0) -> out_gcd=48. All with gcd_start never asserted and out_valid the cycle after accept.
- Backpressure: out_ready=0 for 10 cycles after (36,60) completes -> out_gcd=12 held stable, in_ready=0 throughout; a second in_valid is not accepted until 1 cycle after the out handshake.
- Timeout: TIMEOUT=15, model never asserts done -> out_valid with out_gcd=0 and out_timeout=1 after 16 WAIT cycles. A done on the same cycle as the limit -> result returned with out_timeout=0.
- Reset mid-op: rst_n=0 during WAIT and again during HOLD -> next cycle out_valid=0 and gcd_start=0; in_ready=1 the cycle after rst_n returns high; a fresh pair (17,51) then returns 17.
- Back-to-back: 8 random nonzero pairs with in_valid held high and out_ready=1 -> results match a reference GCD in order, with no transaction lost or duplicated.
